// File: rtl/bsk_prm_sync.sv
// Parallel-bus command register block: complement-checked command words, indication
// outputs, sticky error flags, block/enable gating and a prescaled command watchdog.
module bsk_prm_sync #(
    parameter logic [5:0]  VERSION    = 6'h25,
    parameter logic [7:0]  PASSWORD   = 8'hA6,
    parameter logic [3:0]  CS         = 4'b0111,
    parameter int          NWORD      = 2,
    parameter int          WD_PRE     = 1000,
    parameter logic [14:0] WD_DEFAULT = 15'd0,
    localparam int         NCOM       = 8*NWORD
) (
    input  logic            iClk,
    input  logic            iRes,
    inout  wire  [15:0]     bD,
    input  logic            iRd,
    input  logic            iWr,
    input  logic            iBl,
    input  logic            iKEnable,
    input  logic [3:0]      iA,
    input  logic [3:0]      iCS,
    input  logic [NCOM-1:0] iComT,
    output logic [NCOM-1:0] oCom,
    output logic [NCOM-1:0] oComInd,
    output logic            oCS,
    output logic            oEnable,
    output logic            oWdErr
);
    localparam int NERR = 2*NWORD;
    localparam int PW   = (WD_PRE > 1) ? $clog2(WD_PRE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(WD_PRE - 1);

    logic            r_wr_s1, r_wr_s2, r_wr_prev, r_wr_dly, r_wr_arm;
    logic            r_bl_s1, r_bl_s2;
    logic [15:0]     r_raw [NWORD];
    logic [NCOM-1:0] r_com, r_cind, r_ocom, r_ocind;
    logic [NERR-1:0] r_err, r_sticky;
    logic [7:0]      r_ctrl;
    logic [14:0]     r_wd_period, r_wd_cnt;
    logic [PW-1:0]   r_wd_pre;
    logic            r_wd_exp, r_wd_n;

    logic            w_cs_hit, w_we, w_cmd, w_enable, w_e_lo, w_e_hi;
    logic [15:0]     w_rdata;

    assign w_cs_hit = (iCS == CS);
    // Arming requires a genuinely high iWr after reset, so a pulse cut by reset is dropped.
    assign w_we     = !r_wr_s2 && r_wr_prev && r_wr_arm && w_cs_hit;
    assign w_cmd    = (iA < 4'(NWORD));
    assign w_enable = (r_ctrl == 8'hE1);
    assign w_e_lo   = (bD[3:0]  != ~bD[7:4]);
    assign w_e_hi   = (bD[11:8] != ~bD[15:12]);

    always_ff @(posedge iClk) begin
        if (iRes) begin
            r_wr_s1     <= 1'b1;
            r_wr_s2     <= 1'b1;
            r_wr_prev   <= 1'b1;
            r_wr_dly    <= 1'b0;
            r_wr_arm    <= 1'b0;
            r_bl_s1     <= 1'b1;
            r_bl_s2     <= 1'b1;
            for (int k = 0; k < NWORD; k++) r_raw[k] <= '0;
            r_com       <= '0;
            r_cind      <= '0;
            r_err       <= '1;
            r_sticky    <= '0;
            r_ctrl      <= '0;
            r_wd_period <= WD_DEFAULT;
            r_wd_cnt    <= WD_DEFAULT;
            r_wd_pre    <= '0;
            r_wd_exp    <= 1'b0;
            r_ocom      <= '1;
            r_ocind     <= '1;
            r_wd_n      <= 1'b1;
        end else begin
            r_wr_s1   <= iWr;
            r_wr_s2   <= r_wr_s1;
            r_wr_prev <= r_wr_s2;
            r_wr_dly  <= 1'b1;
            if (r_wr_dly && r_wr_s1 && r_wr_s2 && r_wr_prev) r_wr_arm <= 1'b1;
            r_bl_s1   <= iBl;
            r_bl_s2   <= r_bl_s1;

            r_ocom  <= ((|r_err) || !r_bl_s2 || r_wd_exp) ? '1 : r_com;
            r_ocind <= ~r_cind;
            r_wd_n  <= !r_wd_exp;

            if (r_wd_period == '0) begin
                r_wd_exp <= 1'b0;
                r_wd_pre <= '0;
            end else if (!r_wd_exp) begin
                if (r_wd_pre == PRE_LAST) begin
                    r_wd_pre <= '0;
                    if (r_wd_cnt <= 15'd1) begin
                        r_wd_cnt <= '0;
                        r_wd_exp <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt - 15'd1;
                    end
                end else begin
                    r_wd_pre <= r_wd_pre + PW'(1);
                end
            end

            // Write handling comes last so a reload overrides a coincident expiry.
            if (w_we) begin
                for (int k = 0; k < NWORD; k++) begin
                    if (iA == 4'(k)) begin
                        r_raw[k]          <= bD;
                        r_com[8*k +: 4]   <= bD[7:4];
                        r_com[8*k+4 +: 4] <= bD[15:12];
                        r_err[2*k]        <= w_e_lo;
                        r_err[2*k+1]      <= w_e_hi;
                        r_sticky[2*k]     <= r_sticky[2*k] | w_e_lo;
                        r_sticky[2*k+1]   <= r_sticky[2*k+1] | w_e_hi;
                    end
                end
                for (int j = 0; j < NWORD/2; j++) begin
                    if (iA == 4'(8+j)) r_cind[16*j +: 16] <= bD;
                end
                if (w_cmd) begin
                    r_wd_cnt <= r_wd_period;
                    r_wd_pre <= '0;
                    r_wd_exp <= 1'b0;
                end
                case (iA)
                    4'hC: r_sticky <= r_sticky & ~bD[NERR-1:0];
                    4'hD: begin
                        r_wd_period <= bD[14:0];
                        r_wd_cnt    <= bD[14:0];
                        r_wd_pre    <= '0;
                        r_wd_exp    <= 1'b0;
                    end
                    4'hF: r_ctrl <= bD[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NWORD; k++) begin
            if (iA == 4'(k)) w_rdata = r_raw[k];
        end
        for (int j = 0; j < NWORD/2; j++) begin
            if (iA == 4'(8+j)) w_rdata = iComT[16*j +: 16];
        end
        case (iA)
            4'hC: w_rdata[NERR-1:0] = r_sticky;
            4'hD: w_rdata = {r_wd_exp, r_wd_period};
            4'hF: w_rdata = {PASSWORD, VERSION, iKEnable, !w_enable};
            default: ;
        endcase
    end

    assign bD      = (!iRd && w_cs_hit) ? w_rdata : 16'hzzzz;
    assign oCom    = r_ocom;
    assign oComInd = r_ocind;
    assign oWdErr  = r_wd_n;
    assign oCS     = !w_cs_hit;
    assign oEnable = !w_enable || !r_bl_s2;
endmodule

// File: tb/tb_bsk_prm_sync.sv
// Self-checking bench for bsk_prm_sync: vector table, directed corner sequences and
// randomized bus traffic checked against a register-level reference model.
module tb_bsk_prm_sync;
    localparam int          NWORD = 4;
    localparam int          NCOM  = 32;
    localparam logic [3:0]  CS    = 4'b0111;

    logic            iClk = 1'b0;
    logic            iRes, iRd, iWr, iBl, iKEnable;
    logic [3:0]      iA, iCS;
    logic [NCOM-1:0] iComT;
    wire  [NCOM-1:0] oCom, oComInd;
    wire             oCS, oEnable, oWdErr;
    logic [15:0]     r_bd;
    logic            r_bd_en;
    wire  [15:0]     bD;

    assign bD = r_bd_en ? r_bd : 16'hzzzz;

    bsk_prm_sync #(.NWORD(NWORD), .WD_PRE(4)) dut (
        .iClk(iClk), .iRes(iRes), .bD(bD), .iRd(iRd), .iWr(iWr), .iBl(iBl),
        .iKEnable(iKEnable), .iA(iA), .iCS(iCS), .iComT(iComT),
        .oCom(oCom), .oComInd(oComInd), .oCS(oCS), .oEnable(oEnable), .oWdErr(oWdErr)
    );

    always #5 iClk = ~iClk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    logic [15:0] m_raw [NWORD];
    bit          m_wr  [NWORD];
    logic [7:0]  m_sticky;
    logic [31:0] m_cind;
    logic [7:0]  m_ctrl;
    logic [14:0] m_period;
    bit          m_exp;
    bit          m_bl;

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl [14];

    logic [15:0] v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iClk);
    endtask

    function automatic logic [1:0] word_err(input logic [15:0] d);
        return {(d[11:8] != ~d[15:12]), (d[3:0] != ~d[7:4])};
    endfunction

    function automatic logic [31:0] exp_ocom();
        logic [31:0] c = '0;
        bit bad = m_exp || !m_bl;
        for (int k = 0; k < NWORD; k++) begin
            if (!m_wr[k] || word_err(m_raw[k]) != 2'b00) bad = 1;
            c[8*k +: 8] = {m_raw[k][15:12], m_raw[k][7:4]};
        end
        return bad ? 32'hFFFF_FFFF : c;
    endfunction

    function automatic logic [15:0] exp_read(input logic [3:0] a);
        int ai = int'(a);
        if (ai < NWORD) return m_raw[ai];
        case (a)
            4'h8: return iComT[15:0];
            4'h9: return iComT[31:16];
            4'hC: return {8'h00, m_sticky};
            4'hD: return {m_exp, m_period};
            4'hF: return {8'hA6, 6'h25, iKEnable, !(m_ctrl == 8'hE1)};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NWORD; k++) begin
            m_raw[k] = '0;
            m_wr[k]  = 0;
        end
        m_sticky = '0; m_cind = '0; m_ctrl = '0; m_period = '0; m_exp = 0;
    endtask

    task automatic m_write(input logic [3:0] a, input logic [15:0] d);
        int ai = int'(a);
        if (ai < NWORD) begin
            m_raw[ai] = d;
            m_wr[ai]  = 1;
            m_sticky[2*ai +: 2] = m_sticky[2*ai +: 2] | word_err(d);
            m_exp = 0;
        end
        case (a)
            4'h8: m_cind[15:0]  = d;
            4'h9: m_cind[31:16] = d;
            4'hC: m_sticky = m_sticky & ~d[7:0];
            4'hD: begin m_period = d[14:0]; m_exp = 0; end
            4'hF: m_ctrl = d[7:0];
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ocom"},   oCom,    exp_ocom());
        check({tag, "_ocind"},  oComInd, ~m_cind);
        check({tag, "_oen"},    {31'd0, oEnable}, {31'd0, !(m_ctrl == 8'hE1) || !m_bl});
        check({tag, "_owderr"}, {31'd0, oWdErr},  {31'd0, !m_exp});
    endtask

    // Returns at the falling edge just after W+1, with the bus still driven.
    task automatic write_start(input logic [3:0] a, input logic [15:0] d, input logic [3:0] cs);
        @(negedge iClk);
        iA = a; iCS = cs; r_bd = d; r_bd_en = 1'b1; iWr = 1'b0;
        cyc(4);
    endtask

    task automatic write_end();
        iWr = 1'b1;
        cyc(4);
        r_bd_en = 1'b0;
        iCS = CS;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [3:0] cs);
        write_start(a, d, cs);
        if (cs == CS) m_write(a, d);
        check_outputs("wr");
        write_end();
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] val);
        @(negedge iClk);
        iA = a; iCS = CS; iRd = 1'b0;
        #2;
        val = bD;
        iRd = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRes = 1'b1;
        cyc(3);
        iRes = 1'b0;
        m_reset();
        cyc(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want done");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ra, rcs;
        logic [15:0] rdat;
        logic [3:0]  n;

        iRes = 1'b1; iRd = 1'b1; iWr = 1'b1; iBl = 1'b1; iKEnable = 1'b1;
        iA = '0; iCS = CS; iComT = 32'h1234_5678; r_bd = '0; r_bd_en = 1'b0;
        m_bl = 1;
        m_reset();
        do_reset();

        check("rst_ocom",   oCom,    32'hFFFF_FFFF);
        check("rst_ocind",  oComInd, 32'hFFFF_FFFF);
        check("rst_oen",    {31'd0, oEnable}, 32'd1);
        check("rst_owderr", {31'd0, oWdErr},  32'd1);
        rd(4'hF, v); check("rst_id",     {16'd0, v}, 32'h0000_A697);
        rd(4'hC, v); check("rst_sticky", {16'd0, v}, 32'h0);
        rd(4'hD, v); check("rst_wd",     {16'd0, v}, 32'h0);

        tbl[0]  = '{1'b1, 4'h1, 16'h5AA5, 16'h0000};
        tbl[1]  = '{1'b1, 4'h2, 16'hF00F, 16'h0000};
        tbl[2]  = '{1'b1, 4'h3, 16'h3CC3, 16'h0000};
        tbl[3]  = '{1'b1, 4'h0, 16'hA55A, 16'h0000};
        tbl[4]  = '{1'b0, 4'h0, 16'h0000, 16'hA55A};
        tbl[5]  = '{1'b0, 4'h3, 16'h0000, 16'h3CC3};
        tbl[6]  = '{1'b0, 4'hC, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b1, 4'h9, 16'hBEEF, 16'h0000};
        tbl[8]  = '{1'b0, 4'h9, 16'h0000, 16'h1234};
        tbl[9]  = '{1'b0, 4'h8, 16'h0000, 16'h5678};
        tbl[10] = '{1'b1, 4'hB, 16'h1111, 16'h0000};
        tbl[11] = '{1'b0, 4'hB, 16'h0000, 16'h0000};
        tbl[12] = '{1'b1, 4'h5, 16'h1234, 16'h0000};
        tbl[13] = '{1'b0, 4'h5, 16'h0000, 16'h0000};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                wr(tbl[i].a, tbl[i].d, CS);
            end else begin
                rd(tbl[i].a, v);
                check($sformatf("tbl%0d_rd", i), {16'd0, v}, {16'd0, tbl[i].exp_rd});
            end
        end
        check("tbl_ocom_all", oCom,    32'h3CF0_5AA5);
        check("tbl_ocind",    oComInd, 32'h4110_FFFF);

        // complement error, sticky flag and W1C clear
        wr(4'h0, 16'hA55B, CS);
        check("err_ocom_ones", oCom, 32'hFFFF_FFFF);
        rd(4'hC, v); check("err_sticky", {16'd0, v}, 32'h0001);
        wr(4'hC, 16'h0001, CS);
        wr(4'h0, 16'hA55A, CS);
        rd(4'hC, v); check("err_sticky_clr", {16'd0, v}, 32'h0);
        check("err_ocom_back", oCom, 32'h3CF0_5AA5);

        // enable control and block input
        wr(4'hF, 16'h00E1, CS);
        check("en_oen", {31'd0, oEnable}, 32'd0);
        rd(4'hF, v); check("en_id", {16'd0, v}, 32'h0000_A696);
        @(negedge iClk);
        iBl = 1'b0;
        cyc(2);
        check("bl_oen_2", {31'd0, oEnable}, 32'd1);
        check("bl_ocom_2", oCom, 32'h3CF0_5AA5);
        cyc(1);
        check("bl_ocom_3", oCom, 32'hFFFF_FFFF);
        iBl = 1'b1;
        cyc(4);
        check_outputs("bl_release");

        // watchdog: period 3 ticks of 4 clocks, expiry 12 clocks after the command write
        wr(4'hD, 16'h0003, CS);
        rd(4'hD, v); check("wd_period", {16'd0, v}, 32'h0003);
        wr(4'h0, 16'hA55A, CS);
        cyc(7);
        check("wd_w12", {31'd0, oWdErr}, 32'd1);
        cyc(1);
        check("wd_w13", {31'd0, oWdErr}, 32'd0);
        check("wd_ocom", oCom, 32'hFFFF_FFFF);
        m_exp = 1;
        rd(4'hD, v); check("wd_rd_exp", {16'd0, v}, 32'h8003);
        wr(4'h0, 16'hA55A, CS);
        check("wd_cleared", {31'd0, oWdErr}, 32'd1);
        wr(4'hD, 16'h0000, CS);

        // reset coinciding with the write event
        @(negedge iClk);
        iA = 4'h0; iCS = CS; r_bd = 16'hA55A; r_bd_en = 1'b1; iWr = 1'b0;
        cyc(2);
        iRes = 1'b1;
        cyc(2);
        iRes = 1'b0;
        m_reset();
        cyc(4);
        iWr = 1'b1;
        cyc(4);
        r_bd_en = 1'b0;
        check_outputs("rstw");
        rd(4'h0, v); check("rstw_raw", {16'd0, v}, 32'h0);
        rd(4'hC, v); check("rstw_sticky", {16'd0, v}, 32'h0);
        @(negedge iClk);
        iCS = CS;   #1 check("ocs_hit",  {31'd0, oCS}, 32'd0);
        iCS = 4'h0; #1 check("ocs_miss", {31'd0, oCS}, 32'd1);
        iCS = CS;
        wr(4'h0, 16'hA55A, CS);
        rd(4'h0, v); check("rstw_next", {16'd0, v}, 32'h0000_A55A);

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            iComT = $urandom;
            iKEnable = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1: begin
                    ra = 4'($urandom_range(0, 15));
                    if (ra == 4'hD) ra = 4'hE;
                    rdat = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        n = 4'($urandom); rdat[7:4]   = n; rdat[3:0]  = ~n;
                        n = 4'($urandom); rdat[15:12] = n; rdat[11:8] = ~n;
                    end
                    if (ra == 4'hF && $urandom_range(0, 1) == 1) rdat[7:0] = 8'hE1;
                    rcs = ($urandom_range(0, 7) == 0) ? (CS ^ 4'($urandom_range(1, 15))) : CS;
                    wr(ra, rdat, rcs);
                end
                2: begin
                    ra = 4'($urandom_range(0, 15));
                    rd(ra, v);
                    check($sformatf("rnd_rd_a%0h", ra), {16'd0, v}, {16'd0, exp_read(ra)});
                end
                default: begin
                    @(negedge iClk);
                    iCS = 4'($urandom);
                    #1 check("rnd_ocs", {31'd0, oCS}, {31'd0, iCS != CS});
                    iCS = CS;
                end
            endcase
        end
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/bsk_prm_sync.md
BSK_PRM_SYNC -- requirements
Module: bsk_prm_sync

Interface
REQ-001 SHALL have parameter VERSION, default 6'h25, firmware version returned in ID word.
REQ-002 SHALL have parameter PASSWORD, default 8'hA6, board password returned in ID word.
REQ-003 SHALL have parameter CS, default 4'b0111, chip address matched against iCS.
REQ-004 SHALL have parameter NWORD, default 2, number of command words; even, 2..8; NCOM = 8*NWORD.
REQ-005 SHALL have parameter WD_PRE, default 1000, watchdog tick prescaler in iClk cycles.
REQ-006 SHALL have parameter WD_DEFAULT, default 15'd0, watchdog period after reset in ticks; 0 disables.
REQ-007 SHALL have ports: iClk in 1, the single clock; iRes in 1, reset, synchronous, active-high.
REQ-008 SHALL have ports: bD inout 16, data bus; iRd in 1, read strobe, active 0; iWr in 1, write strobe, active 0.
REQ-009 SHALL have ports: iBl in 1, block, active 0; iKEnable in 1, terminal status; iA in 4, address; iCS in 4, chip select.
REQ-010 SHALL have ports: iComT in NCOM, command test inputs; oCom out NCOM, commands, active 0; oComInd out NCOM, indication, active 0.
REQ-011 SHALL have ports: oCS out 1, active 0 when iCS==CS; oEnable out 1, terminal enable, active 0; oWdErr out 1, watchdog expired, active 0.

Function
REQ-012 SHALL pass iWr and iBl through 2-FF synchronizers; write event W = first iClk edge where synchronized iWr is 0 and its previous value was 1.
REQ-013 SHALL sample iA, iCS and bD at W; write accepted only if iCS==CS; registers update at W, oCom/oComInd/oWdErr (registered) change at W+1.
REQ-014 SHALL accept a write at most once per iWr low pulse; minimum iWr low and high time 3 iClk cycles.
REQ-015 SHALL map address k (0..NWORD-1) write: com[8k+3:8k]=bD[7:4], com[8k+7:8k+4]=bD[15:12], err[2k]=(bD[3:0]!=~bD[7:4]), err[2k+1]=(bD[11:8]!=~bD[15:12]); raw word stored.
REQ-016 SHALL map address 8+j (j<NWORD/2) write: com_ind[16j+15:16j]=bD.
REQ-017 SHALL map 0xC write: sticky error flags cleared where bD bit=1 (W1C); 0xD write: watchdog period=bD[14:0], counter reloaded; 0xF write: control=bD[7:0].
REQ-018 SHALL ignore writes to unmapped addresses; reads of unmapped addresses return 16'h0000.
REQ-019 SHALL set sticky flag bit n whenever err[n] is set by a write; sticky bits above 2*NWORD-1 read 0.
REQ-020 SHALL drive oCom all ones when any err bit set, or synchronized iBl==0, or watchdog expired; else oCom=~com... drive oCom=com (active 0 convention as stored).
REQ-021 SHALL drive oComInd=~com_ind; enable=(control==8'hE1); oEnable=!enable || !iBl_sync; oCS=!(iCS==CS) combinationally.
REQ-022 SHALL run watchdog when period!=0: prescaler counts WD_PRE iClk per tick; counter decrements per tick; at 0 sets expired; period 0 holds expired=0.
REQ-023 SHALL reload counter and clear expired on every accepted command-word write (addresses 0..NWORD-1), regardless of complement error.
REQ-024 SHALL give write priority over expiry in the same cycle (reload wins, expired stays 0).
REQ-025 SHALL drive bD=data when iRd==0 and iCS==CS, else high-Z, combinationally (no clock).
REQ-026 SHALL return on read: addr k raw stored word; addr 8+j iComT[16j+15:16j]; 0xC sticky flags; 0xD {expired, period}; 0xF {PASSWORD, VERSION, iKEnable, !enable}.

Reset
REQ-027 SHALL, at iClk edge with iRes=1: control=0, com=0, err=all 1, sticky=0, com_ind=0, raw words=0, period=WD_DEFAULT, counter=WD_DEFAULT, prescaler=0, expired=0, sync flops=1.
REQ-028 SHALL give iRes priority over a coincident write event; write in progress during reset is discarded, next falling iWr after reset release accepted.
REQ-029 SHALL, after reset, drive oCom all ones, oComInd all ones, oEnable=1, oWdErr=1.

Verification
REQ-030 Reset, write 0x0=16'h5AA5? -> use 16'hA55A (valid both nibbles): oCom[7:0]=8'hA5 at W+1, sticky=0.
REQ-031 Write 0x0=16'hA55B -> err[0]=1, oCom all ones, read 0xC=16'h0001; write 0xC=16'h0001 then valid word -> sticky 0, oCom restored.
REQ-032 WD_PRE=4, write 0xD=15'd3, valid command, idle -> oWdErr=0 and oCom all ones after 12 iClk; rewrite command -> oWdErr=1 next cycle.
REQ-033 Write 0xF=8'hE1, iBl=1 -> oEnable=0, read 0xF bit0=0; drive iBl=0 -> oEnable=1, oCom all ones after 3 edges.
REQ-034 NWORD=4: write 0x3, 0x9, read 0x9 with iComT[31:16]=16'h1234 -> bD=16'h1234; write to 0xB and 0x5 ignored, reads 0.
REQ-035 Assert iRes on W of a command write -> com unchanged (0), err all 1; oCS tracks iCS throughout.
